// File: rtl/elevator_pkg.sv
// Shared state encoding and request-mask helpers for the N-floor elevator controller.
package elevator_pkg;

    localparam int MAX_FLOORS = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR      = 3'd3,
        ESTOP     = 3'd4
    } state_t;

    // Callers zero-extend their FLOORS-wide pending vector to MAX_FLOORS.
    function automatic logic req_above(input logic [MAX_FLOORS-1:0] pending, input int floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > floor && pending[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic req_below(input logic [MAX_FLOORS-1:0] pending, input int floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < floor && pending[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-request register with clear-over-set priority, plus above/below/here
// flags evaluated at look_floor (the floor the car occupies after this edge).
module elevator_req_reg #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  floor_req,
    input  logic               clr_en,
    input  logic [FLOOR_W-1:0] look_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               above,
    output logic               below,
    output logic               here
);
    import elevator_pkg::*;

    logic [FLOORS-1:0] clr;

    always_comb begin
        clr = '0;
        if (clr_en) clr[look_floor] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | floor_req) & ~clr;
        end
    end

    always_comb begin
        above = req_above(MAX_FLOORS'(pending), int'(look_floor));
        below = req_below(MAX_FLOORS'(pending), int'(look_floor));
        here  = pending[look_floor];
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: SCAN scheduling, timed travel and door dwell,
// emergency halt. Outputs are registered from the next-state decode.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | stationary, door closed, choosing next move
// MOVE_UP   | travelling up, travel counter running
// MOVE_DOWN | travelling down, travel counter running
// DOOR      | stopped at current_floor, door counter running
// ESTOP     | emergency halt, counters cleared
module elevator_ctrl_n #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  floor_req,
    input  logic               emergency_stop,
    output logic               move_up,
    output logic               move_down,
    output logic               motor_stop,
    output logic               door_open,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               dir_up
);
    import elevator_pkg::*;

    localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

    state_t               state, state_next;
    logic [TRAVEL_W-1:0]  travel_cnt, travel_d;
    logic [DOOR_W-1:0]    door_cnt, door_d;
    logic [FLOOR_W-1:0]   look_floor, floor_d;
    logic                 dir_d, mu_d, md_d;
    logic                 travel_tc, door_tc, arrive, reload, clr_en;
    logic                 above, below, here;

    elevator_req_reg #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_req_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .floor_req  (floor_req),
        .clr_en     (clr_en),
        .look_floor (look_floor),
        .pending    (pending),
        .above      (above),
        .below      (below),
        .here       (here)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            current_floor <= '0;
            dir_up        <= 1'b1;
            move_up       <= 1'b0;
            move_down     <= 1'b0;
            motor_stop    <= 1'b1;
            door_open     <= 1'b0;
        end else begin
            state         <= state_next;
            travel_cnt    <= travel_d;
            door_cnt      <= door_d;
            current_floor <= floor_d;
            dir_up        <= dir_d;
            move_up       <= mu_d;
            move_down     <= md_d;
            motor_stop    <= ~(mu_d | md_d);
            door_open     <= (state_next == DOOR);
        end
    end

    always_comb begin
        state_next = state;
        travel_tc  = (travel_cnt == TRAVEL_LAST);
        door_tc    = (door_cnt == DOOR_LAST);
        arrive     = (state == MOVE_UP || state == MOVE_DOWN) && travel_tc;
        reload     = (state == DOOR) && floor_req[current_floor];

        // Flags are evaluated at the arrival floor so a stop is decided on the arrival edge.
        look_floor = current_floor;
        if (arrive) begin
            look_floor = (state == MOVE_UP) ? current_floor + 1'b1 : current_floor - 1'b1;
        end

        case (state)
            IDLE: begin
                if (here)                         state_next = DOOR;
                else if (above && (dir_up || !below)) state_next = MOVE_UP;
                else if (below)                   state_next = MOVE_DOWN;
            end
            MOVE_UP: begin
                if (travel_tc) begin
                    if (here)       state_next = DOOR;
                    else if (!above) state_next = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (travel_tc) begin
                    if (here)       state_next = DOOR;
                    else if (!below) state_next = IDLE;
                end
            end
            DOOR: begin
                if (!reload && door_tc) begin
                    if (dir_up && above)       state_next = MOVE_UP;
                    else if (!dir_up && below) state_next = MOVE_DOWN;
                    else if (below)            state_next = MOVE_DOWN;
                    else if (above)            state_next = MOVE_UP;
                    else                       state_next = IDLE;
                end
            end
            ESTOP: begin
                if (!emergency_stop) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (emergency_stop) state_next = ESTOP;

        mu_d    = (state_next == MOVE_UP);
        md_d    = (state_next == MOVE_DOWN);
        dir_d   = mu_d ? 1'b1 : (md_d ? 1'b0 : dir_up);
        clr_en  = (state_next == DOOR);
        floor_d = (arrive && state_next != ESTOP) ? look_floor : current_floor;

        travel_d = '0;
        if ((state == MOVE_UP || state == MOVE_DOWN) && state_next == state && !travel_tc) begin
            travel_d = travel_cnt + 1'b1;
        end

        door_d = '0;
        if (state == DOOR && state_next == DOOR && !reload && !door_tc) begin
            door_d = door_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n (4 floors): a stop scoreboard checks every
// door opening against expected floor and dwell length, plus timed point checks.
module tb_elevator_ctrl_n;

    localparam int FLOORS = 4;
    localparam int FW     = 2;

    logic              clk;
    logic              rst_n;
    logic [FLOORS-1:0] floor_req;
    logic              emergency_stop;
    logic              move_up, move_down, motor_stop, door_open, dir_up;
    logic [FW-1:0]     current_floor;
    logic [FLOORS-1:0] pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int floor;
        int len;
    } stop_t;

    stop_t exp_q[$];
    stop_t cur;
    bit    door_q   = 1'b0;
    int    door_len = 0;
    int    exp_len  = 0;
    int    stop_cnt;
    logic  inv;

    elevator_ctrl_n #(
        .FLOORS        (FLOORS),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .floor_req      (floor_req),
        .emergency_stop (emergency_stop),
        .move_up        (move_up),
        .move_down      (move_down),
        .motor_stop     (motor_stop),
        .door_open      (door_open),
        .current_floor  (current_floor),
        .pending        (pending),
        .dir_up         (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_stop(input int f, input int l);
        stop_t s;
        s.floor = f;
        s.len   = l;
        exp_q.push_back(s);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            inv = ~(move_up | move_down);
            chk("motor_stop_inv", motor_stop, inv);
            if (door_open && !door_q) begin
                chk("stop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("stop_floor", current_floor, cur.floor);
                    exp_len = cur.len;
                end
                door_len = 0;
            end
            if (door_open) door_len++;
            if (!door_open && door_q) chk("door_len", door_len, exp_len);
            door_q = door_open;
        end else begin
            door_q = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0;
        floor_req = '0;
        emergency_stop = 1'b0;
        cyc(2);
        chk("rst_floor", current_floor, 0);
        chk("rst_pending", pending, 0);
        chk("rst_motor_stop", motor_stop, 1);
        chk("rst_door", door_open, 0);
        chk("rst_dir", dir_up, 1);
        rst_n = 1'b1;
        cyc(2);

        // single request 0 -> 2
        push_stop(2, 6);
        floor_req = 4'b0100; cyc(1); floor_req = '0;
        chk("s1_latch", pending, 4'b0100);
        chk("s1_not_moving", move_up, 0);
        cyc(1);
        chk("s1_move_up", move_up, 1);
        chk("s1_dir", dir_up, 1);
        cyc(4);
        chk("s1_floor1", current_floor, 1);
        chk("s1_still_up", move_up, 1);
        cyc(4);
        chk("s1_floor2", current_floor, 2);
        chk("s1_door", door_open, 1);
        chk("s1_stopped", move_up, 0);
        chk("s1_cleared", pending, 0);
        cyc(6);
        chk("s1_door_closed", door_open, 0);
        chk("s1_idle_motor", motor_stop, 1);

        // door reload at floor 2
        push_stop(2, 10);
        floor_req = 4'b0100; cyc(1); floor_req = '0;
        chk("rl_latch", pending, 4'b0100);
        cyc(1);
        chk("rl_door", door_open, 1);
        chk("rl_cleared", pending, 0);
        cyc(3);
        floor_req = 4'b0100; cyc(1); floor_req = '0;
        chk("rl_pending_zero", pending, 0);
        cyc(5);
        chk("rl_still_open", door_open, 1);
        cyc(1);
        chk("rl_closed", door_open, 0);

        // reset while travelling down from floor 2
        floor_req = 4'b0001; cyc(1); floor_req = '0;
        cyc(2);
        chk("rs_moving_down", move_down, 1);
        chk("rs_dir_down", dir_up, 0);
        chk("rs_floor_before", current_floor, 2);
        rst_n = 1'b0;
        #1;
        chk("rs_floor", current_floor, 0);
        chk("rs_pending", pending, 0);
        chk("rs_motor_stop", motor_stop, 1);
        chk("rs_door", door_open, 0);
        chk("rs_move_down", move_down, 0);
        chk("rs_dir", dir_up, 1);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // SCAN: heading to 3, request 0 appears at floor 1
        push_stop(3, 6);
        push_stop(0, 6);
        floor_req = 4'b1000; cyc(1); floor_req = '0;
        cyc(5);
        chk("sc_floor1", current_floor, 1);
        chk("sc_up", move_up, 1);
        floor_req = 4'b0001; cyc(1); floor_req = '0;
        chk("sc_pending", pending, 4'b1001);
        cyc(7);
        chk("sc_floor3", current_floor, 3);
        chk("sc_door3", door_open, 1);
        chk("sc_pending_after3", pending, 4'b0001);
        cyc(6);
        chk("sc_reverse", move_down, 1);
        chk("sc_dir_down", dir_up, 0);
        cyc(12);
        chk("sc_floor0", current_floor, 0);
        chk("sc_door0", door_open, 1);
        chk("sc_pending_empty", pending, 0);
        cyc(6);
        chk("sc_idle", motor_stop, 1);

        // emergency stop during floor 1 -> 2 segment
        push_stop(2, 6);
        floor_req = 4'b0100; cyc(1); floor_req = '0;
        cyc(6);
        chk("es_floor1", current_floor, 1);
        chk("es_moving", move_up, 1);
        emergency_stop = 1'b1;
        cyc(1);
        chk("es_halt_door", door_open, 0);
        stop_cnt = 0;
        for (int i = 0; i < 20 && motor_stop; i++) begin
            stop_cnt++;
            if (stop_cnt == 3) begin
                chk("es_hold_floor", current_floor, 1);
                chk("es_hold_pending", pending, 4'b0100);
                emergency_stop = 1'b0;
            end
            cyc(1);
        end
        emergency_stop = 1'b0;
        chk("es_stop_cycles", stop_cnt, 4);
        chk("es_resume", move_up, 1);
        cyc(3);
        chk("es_full_travel", current_floor, 1);
        cyc(1);
        chk("es_floor2", current_floor, 2);
        chk("es_door", door_open, 1);
        cyc(6);

        // back to floor 0
        push_stop(0, 6);
        floor_req = 4'b0001; cyc(1); floor_req = '0;
        cyc(16);
        chk("rt_floor0", current_floor, 0);
        chk("rt_idle", motor_stop, 1);

        // burst of all floors
        push_stop(0, 6);
        push_stop(1, 6);
        push_stop(2, 6);
        push_stop(3, 6);
        floor_req = 4'b1111; cyc(1); floor_req = '0;
        chk("bu_latch", pending, 4'b1111);
        cyc(1);
        chk("bu_door0", door_open, 1);
        chk("bu_pending", pending, 4'b1110);
        cyc(6);
        chk("bu_up", move_up, 1);
        chk("bu_dir", dir_up, 1);
        cyc(30);
        chk("bu_floor3", current_floor, 3);
        chk("bu_door_closed", door_open, 0);
        chk("bu_pending_empty", pending, 0);
        chk("bu_idle", motor_stop, 1);
        chk("bu_dir_end", dir_up, 1);

        cyc(2);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
# elevator_ctrl_n

Parametrised N-floor elevator controller, successor to the fixed 4-floor controller. It latches floor requests into a pending register and serves them with direction-preserving (SCAN) scheduling. Travel takes a fixed number of cycles per floor, and the door stays open for a timed dwell. Emergency stop overrides every other state. It sits between the hall/car button logic and the motor/door drivers.

## Interface
- FLOORS, 8: number of floors, ≥2.
- FLOOR_W, $clog2(FLOORS): floor index width, derived.
- TRAVEL_CYCLES, 4: clock cycles to travel one floor, ≥1.
- DOOR_CYCLES, 6: cycles the door stays open per stop, ≥1.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- floor_req  in  FLOORS  one bit per floor, sampled every cycle, sticky once latched.
- emergency_stop  in  1  level; while high, the car halts.
- move_up  out  1  motor drives up.
- move_down  out  1  motor drives down.
- motor_stop  out  1  motor idle; always equals ~(move_up | move_down).
- door_open  out  1  door open.
- current_floor  out  FLOOR_W  last floor reached.
- pending  out  FLOORS  latched unserved requests.
- dir_up  out  1  scheduling direction, 1 = up.

## Operation
- States:
  - IDLE: car stationary, door closed.
  - MOVE_UP / MOVE_DOWN: car travelling.
  - DOOR: car stopped at a floor with the door open.
  - ESTOP: emergency halt.
- Request latching: `pending <= (pending | floor_req) & ~clr`.
  - `clr` is a one-hot at current_floor when a stop is serviced.
  - Clear wins over a simultaneous set for the same bit.
- Above/below masks are computed from pending relative to current_floor.
- IDLE transitions, in priority order:
  1. pending[current_floor] set → DOOR.
  2. Else if any request above and (dir_up, or no request below) → MOVE_UP, dir_up=1.
  3. Else if any request below → MOVE_DOWN, dir_up=0.
  4. Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count: current_floor steps ±1 and the counter returns to 0.
  - If the new floor is pending → DOOR; otherwise keep moving.
  - The car never moves past floor 0 or FLOORS-1, because it only moves while a request exists ahead.
- DOOR:
  - Bit current_floor is cleared on entry.
  - The door counter runs DOOR_CYCLES cycles.
  - A new request for current_floor while in DOOR reloads the door counter and is cleared the same cycle.
  - On expiry, SCAN decides:
    1. Any request ahead in dir_up direction → continue that way.
    2. Else any request behind → reverse dir_up and move.
    3. Else → IDLE.
- ESTOP:
  - Entered from any state on the edge after emergency_stop is sampled high.
  - move_up=move_down=0, motor_stop=1, door_open=0.
  - current_floor and pending are held; requests still latch.
  - Travel and door counters reset to 0.
  - On the first cycle emergency_stop is low → IDLE, which re-evaluates normally.
- Outputs are registered and decoded from the next-state value, so they change on the same edge as the state.
- Reset values: state=IDLE, current_floor=0, pending=0, dir_up=1, move_up=0, move_down=0, motor_stop=1, door_open=0, both counters 0.

## Timing
- Request latency:
  - floor_req high at edge k → pending bit set after k.
  - IDLE decision at k+1 → move_up/move_down asserted after edge k+1.
- Travel: exactly TRAVEL_CYCLES edges in MOVE per floor.
  - current_floor updates and DOOR (door_open=1) begin on the same edge.
- Door: door_open stays high for DOOR_CYCLES cycles; each reload restarts the full count.
- emergency_stop: 1-cycle latency to halt, 1-cycle latency to leave ESTOP.
- rst_n asserted mid-travel: immediate asynchronous return to reset values; the car position is lost (current_floor=0).

## Structure
- Package elevator_pkg holds:
  - state encoding constants IDLE/MOVE_UP/MOVE_DOWN/DOOR/ESTOP (3-bit);
  - functions req_above(pending, floor) and req_below(pending, floor).
- Sub-module elevator_req_reg holds the pending register and its set/clear logic, and produces the above/below/here flags.
- The top module contains the FSM, both counters and the output registers.

## Test plan
All scenarios use FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=6.
- Reset: rst_n=0 mid-travel → the same cycle shows current_floor=0, pending=0, motor_stop=1, door_open=0.
- Single request: at floor 0 idle, one-cycle floor_req=4'b0100 → move_up for 8 cycles, current_floor 1 then 2, door_open for 6 cycles, then pending=0 and motor_stop=1.
- SCAN order: car moving up past floor 1 with pending=4'b1001 → stops at 3 first, then reverses (dir_up=0) and stops at 0.
- Emergency: emergency_stop pulsed high for 3 cycles while travelling 0→2 → motor_stop=1 for 3+1 cycles with current_floor and pending held. After release, the car resumes and reaches 2 a full TRAVEL_CYCLES after leaving IDLE.
- Door reload: floor_req for current_floor pulsed on door cycle 4 → door_open lasts 4+6=10 cycles total, and pending stays 0.
- Burst: at floor 0 idle, floor_req=4'b1111 for one cycle → door at 0, then stops at 1, 2 and 3 each with a 6-cycle door, ending in IDLE with pending=0 and dir_up=1.
